// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e : fetch FSM state encoding (2-bit)
//   RESP_OKAY   : AXI4-Lite read response value for a successful read
//   NOP         : instruction emitted when a fetch faults (addi x0,x0,0)
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] NOP       = 32'h0000_0013;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch-unit performance counters.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   xfer       in   an instruction was handed to decode this cycle
//   stall      in   the fetch unit is waiting on the memory bus this cycle
//   perf_fetch out  count of completed decode transfers (wraps at 2^32)
//   perf_stall out  count of bus-wait cycles (wraps at 2^32)
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        xfer,
    input  logic        stall,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);

    logic [31:0] fetch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_q <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (xfer) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (stall) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch = fetch_q;
    assign perf_stall = stall_q;

endmodule

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch stage with an AXI4-Lite-style read master.
// Takes the next PC from writeback, reads the instruction over AR/R, and hands
// {inst, inst_pc, fetch_err} to decode under valid/ready. One instruction in flight.
// Optional feature macro: IFU_PERF_CNT_EN enables the perf_fetch/perf_stall counters;
// without it both outputs are tied to zero.
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   pc_in, pc_valid, pc_ready     next PC from writeback
//   araddr, arvalid, arready      read address channel
//   rdata, rresp, rvalid, rready  read data channel
//   inst, inst_pc, fetch_err,
//   inst_valid, inst_ready        fetched instruction to decode
//   perf_fetch, perf_stall        performance counters
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);

    ifu_state_e  state_q, state_d;
    logic        boot_pend_q, boot_pend_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fetch_err_q, fetch_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            boot_pend_q <= 1'b1;
            fetch_pc_q  <= RESET_PC;
            inst_q      <= NOP_INST;
            inst_pc_q   <= 32'd0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_pend_q <= boot_pend_d;
            fetch_pc_q  <= fetch_pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        boot_pend_d = boot_pend_q;
        fetch_pc_d  = fetch_pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_err_d = fetch_err_q;

        unique case (state_q)
            S_IDLE: begin
                // The first fetch after reset comes from RESET_PC, not from writeback.
                if (boot_pend_q) begin
                    fetch_pc_d  = RESET_PC;
                    boot_pend_d = 1'b0;
                    state_d     = S_AR;
                end else if (pc_valid) begin
                    fetch_pc_d = pc_in;
                    if (pc_in[1:0] == 2'b00) begin
                        state_d = S_AR;
                    end else begin
                        // Misaligned PC: fault locally, never touch the bus.
                        inst_d      = NOP_INST;
                        fetch_err_d = 1'b1;
                        inst_pc_d   = pc_in;
                        state_d     = S_OUT;
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    inst_d      = (rresp == RESP_OKAY) ? rdata : NOP_INST;
                    fetch_err_d = (rresp != RESP_OKAY);
                    inst_pc_d   = fetch_pc_q;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Handshake outputs decode registered state only, so no input reaches an output
    // combinationally.
    assign pc_ready   = (state_q == S_IDLE) && !boot_pend_q;
    assign arvalid    = (state_q == S_AR);
    assign araddr     = fetch_pc_q;
    assign rready     = (state_q == S_R);
    assign inst_valid = (state_q == S_OUT);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;

`ifdef IFU_PERF_CNT_EN
    logic perf_xfer;
    logic perf_wait;

    assign perf_xfer = inst_valid && inst_ready;
    assign perf_wait = (state_q == S_AR) || (state_q == S_R);

    ifu_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .xfer       (perf_xfer),
        .stall      (perf_wait),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
    );
`else
    assign perf_fetch = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: randomized bus/decode timing, a memory
// model, and a scoreboard fed by the PC driver and drained by an output monitor.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;

    ifu_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ar_hs     = 0;
    int   r_hs      = 0;
    int   out_cnt   = 0;
    int   exp_ar    = 0;
    int   ar_dly_cfg = 0;   // <0: random delay
    int   r_dly_cfg  = 0;
    bit   ir_hold   = 1'b0;
    bit   ir_rand   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Memory contents and fault map.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return (a ^ 32'hA5C3_0F69) + 32'h0101_0101;
    endfunction

    function automatic bit mem_err(input logic [31:0] a);
        return a[6:2] == 5'h15;
    endfunction

    // What decode must receive for a given PC.
    function automatic exp_t expect_for(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00 || mem_err(pc)) begin
            e.inst = 32'h0000_0013;
            e.err  = 1'b1;
        end else begin
            e.inst = mem_word(pc);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    function automatic int pick(input int cfg, input int max);
        if (cfg < 0) return int'($urandom_range(0, max));
        return cfg;
    endfunction

    // Memory slave: drives at negedge, resolves handshakes of the preceding posedge.
    initial begin
        bit          ar_active = 1'b0;
        bit          ar_seen   = 1'b0;
        bit          r_seen    = 1'b0;
        bit          r_real    = 1'b0;
        bit          rd_pend   = 1'b0;
        int          ar_wait   = 0;
        int          r_wait    = 0;
        logic [31:0] ar_addr   = 32'd0;
        logic [31:0] rd_addr   = 32'd0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                arready = 1'b0; rvalid = 1'b0;
                ar_active = 1'b0; ar_seen = 1'b0; r_seen = 1'b0; r_real = 1'b0; rd_pend = 1'b0;
                continue;
            end
            if (ar_seen && arready) begin
                ar_hs++;
                rd_pend   = 1'b1;
                rd_addr   = ar_addr;
                r_wait    = pick(r_dly_cfg, 8);
                ar_active = 1'b0;
            end else if (ar_seen) begin
                check("ar_stable_valid", 64'(arvalid), 64'd1);
                check("ar_stable_addr", 64'(araddr), 64'(ar_addr));
            end
            if (r_real && r_seen) begin
                r_hs++;
                rd_pend = 1'b0;
            end
            if (arvalid && !ar_active) begin
                ar_active = 1'b1;
                ar_wait   = pick(ar_dly_cfg, 6);
            end
            if (arvalid) begin
                arready = (ar_wait == 0);
                if (ar_wait > 0) ar_wait--;
            end else begin
                arready = ($urandom_range(0, 3) == 0);
            end
            ar_seen = arvalid;
            ar_addr = araddr;
            if (rd_pend && r_wait == 0) begin
                rvalid = 1'b1;
                rdata  = mem_err(rd_addr) ? 32'hDEAD_BEEF : mem_word(rd_addr);
                rresp  = mem_err(rd_addr) ? 2'b10 : 2'b00;
                r_real = 1'b1;
            end else begin
                if (rd_pend) r_wait--;
                rvalid = rd_pend ? 1'b0 : ($urandom_range(0, 3) == 0);
                rdata  = $urandom;
                rresp  = 2'($urandom);
                r_real = 1'b0;
            end
            r_seen = rready;
        end
    end

    // Decode-side readiness.
    initial begin
        inst_ready = 1'b1;
        forever begin
            @(negedge clk);
            inst_ready = ir_hold ? 1'b0 : (ir_rand ? 1'($urandom) : 1'b1);
        end
    end

    // Output monitor / scoreboard consumer.
    initial begin
        bit          held_v    = 1'b0;
        logic [64:0] held      = 65'd0;
        int          fetch_cnt = 0;
        int          stall_cnt = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                held_v = 1'b0; fetch_cnt = 0; stall_cnt = 0;
                continue;
            end
            if (held_v) begin
                check("out_hold_valid", 64'(inst_valid), 64'd1);
                check("out_hold_data", 64'({inst, inst_pc, fetch_err} ^ held), 64'd0);
            end
            if (inst_valid && inst_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=pc %0h required=none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_inst", 64'(inst), 64'(e.inst));
                    check("out_pc", 64'(inst_pc), 64'(e.pc));
                    check("out_err", 64'(fetch_err), 64'(e.err));
                end
`ifdef IFU_PERF_CNT_EN
                check("perf_fetch", 64'(perf_fetch), 64'(fetch_cnt));
                check("perf_stall", 64'(perf_stall), 64'(stall_cnt));
`else
                check("perf_fetch_tied", 64'(perf_fetch), 64'd0);
                check("perf_stall_tied", 64'(perf_stall), 64'd0);
`endif
                fetch_cnt++;
            end
            held_v = inst_valid && !inst_ready;
            held   = {inst, inst_pc, fetch_err};
            if (arvalid || rready) stall_cnt++;
        end
    end

    task automatic issue(input logic [31:0] pc);
        int n = 0;
        pc_in    = pc;
        pc_valid = 1'b1;
        #2;
        while (!pc_ready && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!pc_ready) begin
            checks++;
            failures++;
            $display("FAIL pc_accept_timeout actual=0 required=1 pc=%0h", pc);
        end else begin
            exp_q.push_back(expect_for(pc));
            if (pc[1:0] == 2'b00) exp_ar++;
        end
        @(negedge clk);
        pc_valid = 1'b0;
        pc_in    = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        #2;
        while ((exp_q.size() != 0 || !pc_ready) && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_timeout", 64'(exp_q.size() != 0 || !pc_ready), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_pc_ready", 64'(pc_ready), 64'd0);
        check("rst_inst", 64'(inst), 64'h13);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);
        check("rst_perf_fetch", 64'(perf_fetch), 64'd0);
        check("rst_perf_stall", 64'(perf_stall), 64'd0);
    endtask

    // Release reset and check the boot fetch timing with zero-wait memory.
    task automatic release_and_boot();
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(expect_for(32'h8000_0000));
        exp_ar++;
        @(negedge clk);
        #2;
        check("boot_arvalid", 64'(arvalid), 64'd1);
        check("boot_araddr", 64'(araddr), 64'h8000_0000);
        @(negedge clk);
        #2;
        check("boot_not_yet_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        #2;
        check("boot_valid_3cyc", 64'(inst_valid), 64'd1);
        check("boot_inst", 64'(inst), 64'h0010_0093);
        check("boot_inst_pc", 64'(inst_pc), 64'h8000_0000);
    endtask

    initial begin
        int a0;
        int r0;
        int o0;
        int n;
        logic [31:0] rnd;
        logic [31:0] pc;
        rst      = 1'b0;
        pc_valid = 1'b0;
        pc_in    = 32'd0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs();

        // Boot fetch.
        release_and_boot();
        wait_drain();

        // Slow address and data channels.
        ar_dly_cfg = 5;
        r_dly_cfg  = 7;
        a0 = ar_hs; r0 = r_hs; o0 = out_cnt;
        issue(32'h8000_0100);
        wait_drain();
        check("slow_one_ar", 64'(ar_hs - a0), 64'd1);
        check("slow_one_r", 64'(r_hs - r0), 64'd1);
        check("slow_one_out", 64'(out_cnt - o0), 64'd1);
        ar_dly_cfg = 0;
        r_dly_cfg  = 0;

        // Decode back-pressure for 10 cycles with stray pc_valid pulses.
        ir_hold = 1'b1;
        o0 = out_cnt;
        issue(32'h8000_0200);
        n = 0;
        #2;
        while (!inst_valid && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("hold_reached_out", 64'(inst_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pc_valid = 1'(i % 2);
            pc_in    = 32'h8000_0300;
            #2;
            check("hold_pc_ready_low", 64'(pc_ready), 64'd0);
        end
        pc_valid = 1'b0;
        ir_hold  = 1'b0;
        @(negedge clk);
        #2;
        check("hold_release_valid", 64'(inst_valid && inst_ready), 64'd1);
        @(negedge clk);
        #2;
        check("hold_accepted", 64'(inst_valid), 64'd0);
        check("hold_one_out", 64'(out_cnt - o0), 64'd1);

        // Misaligned PC: local fault, no bus traffic.
        a0 = ar_hs;
        issue(32'h8000_0006);
        wait_drain();
        check("misalign_no_ar", 64'(ar_hs - a0), 64'd0);

        // Error response.
        issue(32'h8000_0054);
        wait_drain();

        // Randomized traffic.
        ar_dly_cfg = -1;
        r_dly_cfg  = -1;
        ir_rand    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rnd = $urandom;
            pc  = {16'h8000, rnd[15:2], 2'b00};
            if ($urandom_range(0, 5) == 0) pc[1:0] = 2'(1 + $urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(pc);
        end
        wait_drain();
        check("total_ar", 64'(ar_hs), 64'(exp_ar));
        check("total_r", 64'(r_hs), 64'(exp_ar));
        ir_rand = 1'b0;

        // Reset while waiting on read data.
        ar_dly_cfg = 0;
        r_dly_cfg  = 30;
        issue(32'h8000_0400);
        n = 0;
        #2;
        while (!rready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("reach_s_r", 64'(rready), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        r_dly_cfg = 0;
        release_and_boot();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
